// File: rtl/apb_master_arbiter.sv
// Two-requester APB3 master: round-robin arbitration, one outstanding transfer,
// and a wait-state timeout so a hung slave cannot stall either requester.
`timescale 1ns/1ps
module apb_master_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 32
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [1:0]            state_dbg
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_next;
  logic             last_grant;
  logic             owner;
  logic             winner;
  logic             accept;
  logic             timeout_hit;
  logic [CNT_W-1:0] wait_cnt;

  // Handshake: a request transfers on the edge where req_valid[n] & req_ready[n];
  // req_ready is combinational, only in IDLE, and only for the arbitration winner.
  always_comb begin
    winner = ~last_grant;
    case (req_valid)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last_grant;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && !pready && (wait_cnt == TO_LAST);
  assign accept      = |(req_valid & req_ready);
  assign state_dbg   = state;

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so a pending request never sees ready while held in reset.
        if ((|req_valid) && preset) begin
          req_ready[winner] = 1'b1;
          state_next        = SETUP;
        end
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || timeout_hit) state_next = RESP;
      end
      RESP: begin
        rsp_valid[owner] = 1'b1;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        pwrite     <= req_write[winner];
        paddr      <= req_addr[winner*ADDR_W +: ADDR_W];
        pwdata     <= req_wdata[winner*DATA_W +: DATA_W];
        owner      <= winner;
        last_grant <= winner;
      end
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !pready) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ACCESS) begin
        if (pready) begin
          rsp_rdata <= pwrite ? '0 : prdata;
          rsp_err   <= pslverr;
        end else if (timeout_hit) begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter with a timing-level model
// of arbitration, APB phases, slave wait states, errors and timeouts.
`timescale 1ns/1ps
module tb_apb_master_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TO = 8;

  logic          pclk = 1'b0;
  logic          preset = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0, w0 = 1'b0, w1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic [1:0]    req_valid, req_write, req_ready, rsp_valid, state_dbg;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata, pwdata;
  logic [AW-1:0] paddr;
  logic          rsp_err, psel, penable, pwrite;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  assign req_valid = {v1, v0};
  assign req_write = {w1, w0};
  assign req_addr  = {a1, a0};
  assign req_wdata = {d1, d0};

  apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .state_dbg(state_dbg)
  );

  // clock / cycle count
  always #5 pclk = ~pclk;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  typedef struct packed {
    logic          owner;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] slv_rdata;
    logic          slv_err;
    logic          hang;
    logic [1:0]    waits;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic [31:0]   accept;
    logic [31:0]   rsp_cyc;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);

  logic [EXP_W-1:0] exp_q[$];
  logic [1:0]       gnt_log[$];
  int checks = 0;
  int errors = 0;

  logic          plan_fixed = 1'b0;
  logic [1:0]    plan_waits = '0;
  logic          plan_err = 1'b0, plan_hang = 1'b0;
  logic [DW-1:0] plan_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
    return ~last;
  endfunction

  task automatic set_plan(input logic [1:0] waits, input logic err, input logic hang,
                          input logic [DW-1:0] rdata);
    plan_waits = waits; plan_err = err; plan_hang = hang; plan_rdata = rdata;
    plan_fixed = 1'b1;
  endtask

  // driver: hold request until granted, then drop valid after the accept edge
  task automatic drive_req(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k;
    logic got;
    if (n == 0) begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; end
    else        begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
    k = 0;
    got = 1'b0;
    while (!got && k < 300) begin
      @(negedge pclk);
      k++;
      got = req_ready[n] && preset;
    end
    check("grant_wait", {31'd0, got}, 32'd1);
    @(posedge pclk);
    #1;
    if (n == 0) v0 = 1'b0; else v1 = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || v0 || v1) && k < 200) begin
      @(negedge pclk);
      k++;
    end
    check("idle_wait", {31'd0, exp_q.size() == 0}, 32'd1);
    @(posedge pclk);
    #1;
  endtask

  // monitor + scoreboard + behavioural slave, all sampled on the falling edge
  initial begin
    exp_t          e, ne;
    logic          have, n, model_last, eps, epe;
    logic [1:0]    exp_rr, erv;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic          m_write, m_err;
    int            acc;
    model_last = 1'b1;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_write = 1'b0; m_err = 1'b0;
    forever begin
      @(negedge pclk);
      if (!preset) begin
        exp_q.delete();
        model_last = 1'b1;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_write = 1'b0; m_err = 1'b0;
        check("rst_psel", {31'd0, psel}, 32'd0);
        check("rst_penable", {31'd0, penable}, 32'd0);
        check("rst_req_ready", {30'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        check("rst_paddr", {16'd0, paddr}, 32'd0);
        check("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
      end else begin
        have = (exp_q.size() != 0);
        e = have ? exp_t'(exp_q[0]) : '0;

        exp_rr = 2'b00;
        if (!have && req_valid != 2'b00) exp_rr[pick(req_valid, model_last)] = 1'b1;
        check("req_ready", {30'd0, req_ready}, {30'd0, exp_rr});

        eps = 1'b0; epe = 1'b0; erv = 2'b00;
        if (have) begin
          if (cyc == e.accept + 1) eps = 1'b1;
          else if (cyc >= e.accept + 2 && cyc < e.rsp_cyc) begin eps = 1'b1; epe = 1'b1; end
          else if (cyc == e.rsp_cyc) begin
            erv[e.owner] = 1'b1;
            m_rdata = e.exp_rdata;
            m_err   = e.exp_err;
          end
        end
        check("psel", {31'd0, psel}, {31'd0, eps});
        check("penable", {31'd0, penable}, {31'd0, epe});
        check("rsp_valid", {30'd0, rsp_valid}, {30'd0, erv});
        check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, m_rdata});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        check("paddr", {16'd0, paddr}, {16'd0, m_addr});
        check("pwrite", {31'd0, pwrite}, {31'd0, m_write});
        check("pwdata", {16'd0, pwdata}, {16'd0, m_wdata});
        if (have && cyc == e.rsp_cyc) void'(exp_q.pop_front());

        if (!have && (req_valid & req_ready) != 2'b00) begin
          n = pick(req_valid, model_last);
          gnt_log.push_back(req_ready[1] ? 2'd1 : 2'd0);
          ne = '0;
          ne.owner = n;
          ne.write = n ? w1 : w0;
          ne.addr  = n ? a1 : a0;
          ne.wdata = n ? d1 : d0;
          if (plan_fixed) begin
            ne.waits = plan_waits; ne.slv_err = plan_err; ne.hang = plan_hang;
            ne.slv_rdata = plan_rdata;
            plan_fixed = 1'b0;
          end else begin
            ne.waits = 2'($urandom_range(0, 3));
            ne.slv_err = ($urandom_range(0, 3) == 0);
            ne.hang = ($urandom_range(0, 9) == 0);
            ne.slv_rdata = DW'($urandom);
          end
          acc = ne.hang ? TO : int'(ne.waits) + 1;
          ne.accept  = cyc;
          ne.rsp_cyc = cyc + 2 + acc;
          ne.exp_rdata = (ne.write || ne.hang) ? '0 : ne.slv_rdata;
          ne.exp_err   = ne.hang ? 1'b1 : ne.slv_err;
          exp_q.push_back(EXP_W'(ne));
          model_last = n;
          m_addr = ne.addr; m_write = ne.write; m_wdata = ne.wdata;
        end

        // slave: answers only inside the model's ACCESS window, noise elsewhere
        if (exp_q.size() != 0) e = exp_t'(exp_q[0]);
        if (exp_q.size() != 0 && cyc >= e.accept + 2 && cyc < e.rsp_cyc) begin
          pready  = !e.hang && (cyc == e.accept + 2 + e.waits);
          pslverr = pready ? e.slv_err : 1'($urandom_range(0, 1));
          prdata  = pready ? e.slv_rdata : DW'($urandom);
        end else begin
          pready  = 1'($urandom_range(0, 1));
          pslverr = 1'($urandom_range(0, 1));
          prdata  = DW'($urandom);
        end
      end
    end
  end

  // stimulus
  initial begin
    int k;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b1;

    set_plan(2'd0, 1'b0, 1'b0, 16'h0000);
    drive_req(0, 1'b1, 16'h0010, 16'hBEEF);
    wait_idle();

    set_plan(2'd3, 1'b0, 1'b0, 16'h1234);
    drive_req(1, 1'b0, 16'h0024, 16'h0000);
    wait_idle();

    gnt_log.delete();
    fork
      begin
        drive_req(0, 1'b1, 16'h0100, 16'h1111);
        drive_req(0, 1'b0, 16'h0104, 16'h0000);
      end
      begin
        drive_req(1, 1'b0, 16'h0200, 16'h0000);
        drive_req(1, 1'b1, 16'h0204, 16'h2222);
      end
    join
    wait_idle();
    for (int i = 0; i < 4; i++)
      check("grant_order", (i < gnt_log.size()) ? {30'd0, gnt_log[i]} : 32'd3, i % 2);

    set_plan(2'd0, 1'b1, 1'b0, 16'h0000);
    drive_req(0, 1'b1, 16'h0300, 16'h5A5A);
    wait_idle();
    set_plan(2'd1, 1'b0, 1'b0, 16'hCAFE);
    drive_req(1, 1'b0, 16'h0302, 16'h0000);
    wait_idle();

    set_plan(2'd0, 1'b0, 1'b1, 16'hFFFF);
    drive_req(1, 1'b0, 16'h0400, 16'h0000);
    wait_idle();
    set_plan(2'd0, 1'b0, 1'b0, 16'h7777);
    drive_req(0, 1'b0, 16'h0402, 16'h0000);
    wait_idle();

    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge pclk);
        #1;
        drive_req(0, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
      for (int j = 0; j < 15; j++) begin
        repeat ($urandom_range(0, 3)) @(posedge pclk);
        #1;
        drive_req(1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
      end
    join
    wait_idle();

    // reset in the middle of a waited ACCESS phase
    set_plan(2'd3, 1'b0, 1'b0, 16'h1111);
    drive_req(0, 1'b1, 16'h0500, 16'h3333);
    k = 0;
    while (!penable && k < 20) begin
      @(negedge pclk);
      k++;
    end
    check("reach_access", {31'd0, penable}, 32'd1);
    #2 preset = 1'b0;
    #1;
    check("async_psel", {31'd0, psel}, 32'd0);
    check("async_penable", {31'd0, penable}, 32'd0);
    check("async_req_ready", {30'd0, req_ready}, 32'd0);
    check("async_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    gnt_log.delete();
    fork
      begin
        repeat (3) @(posedge pclk);
        #1 preset = 1'b1;
      end
      drive_req(0, 1'b0, 16'h0600, 16'h0000);
      drive_req(1, 1'b1, 16'h0602, 16'h4444);
    join
    wait_idle();
    check("post_reset_first", (gnt_log.size() > 0) ? {30'd0, gnt_log[0]} : 32'd3, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-port APB3 bus master. It arbitrates between two internal requesters, for example the DRAM controller configuration/CSR sequencer and the debug/host command path.
- It drives a single APB master interface (psel/penable/pwrite/paddr/pwdata) and returns read data and error status to the requester that owns the transfer.
- Round-robin fairness and a wait-state timeout guarantee forward progress when a slave hangs.

Parameters:
- ADDR_W, 16, APB address width (paddr).
- DATA_W, 16, APB data width (pwdata/prdata).
- TIMEOUT, 32, max ACCESS cycles with pready=0 before abort; 0 disables timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester transfer request (bit0 = requester 0).
- req_write  in  2  per-requester direction, 1 = write.
- req_addr  in  2*ADDR_W  per-requester address; requester n occupies bits [n*ADDR_W +: ADDR_W].
- req_wdata  in  2*DATA_W  per-requester write data, same packing as req_addr.
- req_ready  out  2  one-hot accept pulse.
- rsp_valid  out  2  one-hot completion pulse.
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
- rsp_err  out  1  slave error or timeout, valid with rsp_valid.
- psel, penable, pwrite  out  1 each  APB master controls.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.

Behaviour:
- Reset (preset=0, asynchronous) forces the following immediately, with no wait for a clock edge:
  - state IDLE.
  - Outputs psel, penable, pwrite, paddr, pwdata, req_ready, rsp_valid, rsp_rdata, rsp_err all 0.
  - Round-robin pointer last_grant=1, so requester 0 wins the first tie.
  - Wait counter 0.
- Reset mid-transfer: the transfer is dropped, no rsp_valid is issued, and the bus returns idle.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE:
  - psel=0, penable=0.
  - If any req_valid bit is set, grant a winner:
    - only one valid: that requester wins;
    - both valid: the requester != last_grant wins.
  - req_ready[winner]=1 combinationally in the same cycle; the handshake completes on req_valid&req_ready.
  - On that edge: latch req_write/req_addr/req_wdata into pwrite/paddr/pwdata, record owner, set last_grant=owner, go to SETUP.
- SETUP: psel=1, penable=0, exactly 1 cycle, then ACCESS with the wait counter cleared.
- ACCESS:
  - psel=1, penable=1.
  - pready=1: capture prdata into rsp_rdata if a read (0 if a write), capture pslverr into rsp_err, deassert psel/penable on the next edge, go to RESP.
  - pready=0: increment the wait counter.
  - TIMEOUT!=0 and counter reaches TIMEOUT with pready still 0: abort. Set rsp_rdata=0 and rsp_err=1, deassert psel/penable, go to RESP.
  - pslverr is ignored unless pready=1.
- RESP:
  - psel=0, penable=0.
  - rsp_valid[owner]=1 for exactly one cycle; rsp_rdata/rsp_err are valid in the same cycle.
  - Next state IDLE.
  - rsp_rdata/rsp_err hold until the next completion.
- Bus stability: paddr/pwrite/pwdata are stable from SETUP through the end of ACCESS and retain their last values while idle. They change only on a grant.
- Latency with a zero-wait slave: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid T+3, next grant earliest T+4. Each wait state adds 1 cycle.
- Requester rules:
  - A requester must hold req_valid and payload stable until req_ready.
  - Deasserting req_valid before a grant has no effect.
  - A requester not granted sees req_ready=0.
  - Only one transfer is ever outstanding.
- Simultaneous events:
  - Both requesters valid every cycle: grants strictly alternate 0,1,0,1.
  - A new req_valid arriving during SETUP/ACCESS/RESP waits for IDLE.
- Never drive penable=1 with psel=0. Never assert both req_ready bits, and never both rsp_valid bits.

Test Plan:
- Single write, zero-wait slave: req0 write addr=0x0010 wdata=0xBEEF -> req_ready[0] at T; psel=1/penable=0 at T+1; penable=1, paddr=0x0010, pwdata=0xBEEF, pwrite=1 at T+2; rsp_valid=2'b01, rsp_err=0 at T+3.
- Read with 3 wait states: req1 read addr=0x0024, slave returns prdata=0x1234 on the 4th ACCESS cycle -> penable held 4 cycles, paddr stable; rsp_valid=2'b10, rsp_rdata=0x1234, rsp_err=0.
- Contention: both requesters valid continuously for 4 transfers -> grant order 0,1,0,1; each completion pulses only the owner's rsp_valid bit.
- Slave error: pslverr=1 with pready=1 on a write -> rsp_err=1 for that response; the next transfer completes with rsp_err=0.
- Timeout: TIMEOUT=8, pready held 0 -> abort after 8 ACCESS cycles; psel=0 next cycle; rsp_err=1, rsp_rdata=0; the bus then accepts the next request.
- Async reset asserted during ACCESS -> psel/penable/req_ready/rsp_valid go to 0 without waiting for a clock edge; no response is issued. After release, a pending req0 is granted first.
